control_step_sequencer: RTL and testbench

//  Parametrised control-step generator replacing hand-sequenced T0..T5 strobes.

---
 rtl/control_step_sequencer_if.sv | 66 ++++++
 rtl/control_step_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_control_step_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_step_sequencer_if.sv
// ---------------------------------------------------------------------------
// control_step_sequencer_if
//
// Purpose:
//   Bundles the control-unit side of the step sequencer into one interface.
//   The control unit, or a testbench standing in for it, takes the master
//   modport. The sequencer takes the slave modport.
//
// Signals (direction seen from the sequencer / slave):
//   run          in   start/resume request, level sampled each cycle
//   stop         in   halt request, honoured at the next instruction boundary
//   last_step    in   decoder flag: current step is the final execute step
//   mem_access   in   current step performs a memory read/write
//   mem_ready    in   memory completes the access this cycle
//   step_onehot  out  one-hot step strobes T0..T(MAX_STEPS-1)
//   step_num     out  binary index of the current step
//   stall        out  high while waiting on memory
//   instr_done   out  one-cycle pulse after an instruction's final step
//   halted       out  high while halted
//   timeout      out  sticky memory-wait overflow flag
// ---------------------------------------------------------------------------
interface control_step_sequencer_if #(
    parameter int MAX_STEPS = 8
);
    localparam int SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    logic                 run;
    logic                 stop;
    logic                 last_step;
    logic                 mem_access;
    logic                 mem_ready;
    logic [MAX_STEPS-1:0] step_onehot;
    logic [SW-1:0]        step_num;
    logic                 stall;
    logic                 instr_done;
    logic                 halted;
    logic                 timeout;

    modport master (
        output run,
        output stop,
        output last_step,
        output mem_access,
        output mem_ready,
        input  step_onehot,
        input  step_num,
        input  stall,
        input  instr_done,
        input  halted,
        input  timeout
    );

    modport slave (
        input  run,
        input  stop,
        input  last_step,
        input  mem_access,
        input  mem_ready,
        output step_onehot,
        output step_num,
        output stall,
        output instr_done,
        output halted,
        output timeout
    );
endinterface

// File: rtl/control_step_sequencer.sv
// ---------------------------------------------------------------------------
// control_step_sequencer
//
// Purpose:
//   Parametrised control-step generator for the control unit. It emits
//   one-hot step strobes T0..T(MAX_STEPS-1) and stalls on memory handshakes.
//   Each instruction ends on the decoder's last_step flag, or on the final
//   step. It supports run, halt and single-step, and it halts with a sticky
//   timeout flag if a memory wait lasts too long.
//
// Parameters:
//   MAX_STEPS    number of control steps; the last step always ends the instr
//   FETCH_STEPS  leading fetch steps during which last_step is ignored
//   WAIT_LIMIT   max stalled cycles on one memory step before timeout
//
// Ports:
//   clk    in   rising-edge clock
//   clear  in   asynchronous active-high reset
//   bus    slave modport of control_step_sequencer_if
//          (run/stop/last_step/mem_access/mem_ready in;
//           step_onehot/step_num/stall/instr_done/halted/timeout out)
//
// All outputs come straight from flops. Their next values are derived from
// the next-state values, so the outputs line up with the state register.
// ---------------------------------------------------------------------------
module control_step_sequencer #(
    parameter int MAX_STEPS   = 8,
    parameter int FETCH_STEPS = 3,
    parameter int WAIT_LIMIT  = 15
) (
    input  logic                     clk,
    input  logic                     clear,
    control_step_sequencer_if.slave  bus
);

    localparam int SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    localparam logic [SW-1:0] LAST_IDX  = SW'(MAX_STEPS - 1);
    localparam logic [CW-1:0] LIMIT_CNT = CW'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT_MEM,
        S_HALT
    } state_t;

    state_t               state_q,      state_d;
    logic [SW-1:0]        step_q,       step_d;
    logic [CW-1:0]        wait_cnt_q,   wait_cnt_d;
    logic                 stop_pend_q,  stop_pend_d;
    logic                 timeout_q,    timeout_d;
    logic                 instr_done_q, instr_done_d;
    logic [MAX_STEPS-1:0] onehot_q,     onehot_d;
    logic                 stall_q,      stall_d;
    logic                 halted_q,     halted_d;

    logic                 final_step;
    logic                 take_step;

    // The current step closes the instruction when it is the last step.
    // It also closes it when the decoder flags last_step outside the fetch
    // steps; a last_step seen during fetch is ignored.
    always_comb begin
        final_step = (step_q == LAST_IDX) ||
                     (bus.last_step && (int'(step_q) >= FETCH_STEPS));
    end

    // Next-state logic.
    // take_step marks the cycles in which the current step completes.
    // The shared tail below then either advances to the next step or ends
    // the instruction. Ending the instruction is the only way the step
    // counter wraps back to T0.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        wait_cnt_d   = wait_cnt_q;
        stop_pend_d  = stop_pend_q;
        timeout_d    = timeout_q;
        instr_done_d = 1'b0;
        take_step    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.stop) begin
                    stop_pend_d = 1'b1;
                end
                if (bus.run) begin
                    state_d = S_RUN;
                    step_d  = '0;
                end
            end

            S_HALT: begin
                // A stop on its own is ignored while halted. A stop that
                // arrives with run is latched, so exactly one instruction
                // executes before the next halt (single-step).
                if (bus.run) begin
                    state_d   = S_RUN;
                    step_d    = '0;
                    timeout_d = 1'b0;
                    if (bus.stop) begin
                        stop_pend_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (bus.stop) begin
                    stop_pend_d = 1'b1;
                end
                // A stall wins over last_step: the step must finish its
                // memory access before it can end the instruction.
                if (bus.mem_access && !bus.mem_ready) begin
                    state_d    = S_WAIT_MEM;
                    wait_cnt_d = CW'(1);
                end else begin
                    take_step = 1'b1;
                end
            end

            S_WAIT_MEM: begin
                if (bus.stop) begin
                    stop_pend_d = 1'b1;
                end
                if (bus.mem_ready) begin
                    wait_cnt_d = '0;
                    take_step  = 1'b1;
                end else if (wait_cnt_q == LIMIT_CNT) begin
                    // The instruction is abandoned here, so no instr_done
                    // pulse is raised.
                    state_d     = S_HALT;
                    timeout_d   = 1'b1;
                    wait_cnt_d  = '0;
                    step_d      = '0;
                    stop_pend_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
        endcase

        if (take_step) begin
            if (final_step) begin
                instr_done_d = 1'b1;
                step_d       = '0;
                if (stop_pend_q || bus.stop) begin
                    state_d     = S_HALT;
                    stop_pend_d = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end else begin
                state_d = S_RUN;
                step_d  = step_q + SW'(1);
            end
        end
    end

    // The output flops take their values from the next state. This keeps
    // each strobe in the same cycle as the step it names, and the outputs
    // remain glitch-free flop outputs.
    always_comb begin
        stall_d  = (state_d == S_WAIT_MEM);
        halted_d = (state_d == S_HALT);
        if ((state_d == S_RUN) || (state_d == S_WAIT_MEM)) begin
            onehot_d = MAX_STEPS'(1) << step_d;
        end else begin
            onehot_d = '0;
        end
    end

    // Single register stage for the FSM and every output. clear drops the
    // sequencer straight back to IDLE, even mid-wait, and discards any
    // instr_done pulse still in flight.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q      <= S_IDLE;
            step_q       <= '0;
            wait_cnt_q   <= '0;
            stop_pend_q  <= 1'b0;
            timeout_q    <= 1'b0;
            instr_done_q <= 1'b0;
            onehot_q     <= '0;
            stall_q      <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            wait_cnt_q   <= wait_cnt_d;
            stop_pend_q  <= stop_pend_d;
            timeout_q    <= timeout_d;
            instr_done_q <= instr_done_d;
            onehot_q     <= onehot_d;
            stall_q      <= stall_d;
            halted_q     <= halted_d;
        end
    end

    assign bus.step_onehot = onehot_q;
    assign bus.step_num    = step_q;
    assign bus.stall       = stall_q;
    assign bus.instr_done  = instr_done_q;
    assign bus.halted      = halted_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_control_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_step_sequencer
//
// Purpose:
//   Self-checking bench for control_step_sequencer. Each driven cycle runs
//   a behavioural model of the sequencer. The model's prediction of the
//   registered outputs is pushed into a queue. A monitor process pops one
//   prediction after every rising edge and compares it with the DUT outputs.
//   Directed scenarios come first, followed by a long randomized run.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_control_step_sequencer;

    localparam int MAX_STEPS   = 8;
    localparam int FETCH_STEPS = 3;
    localparam int WAIT_LIMIT  = 15;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_WAIT = 2;
    localparam int M_HALT = 3;

    typedef struct packed {
        logic [7:0] onehot;
        logic [2:0] num;
        logic       stall;
        logic       done;
        logic       halted;
        logic       timeout;
    } obs_t;

    logic clk;
    logic clear;

    int   check_count;
    int   error_count;
    obs_t exp_q[$];

    // Behavioural model state
    int   m_mode;
    int   m_step;
    int   m_wait;
    bit   m_pend;
    bit   m_timeout;
    bit   m_done;

    control_step_sequencer_if #(.MAX_STEPS(MAX_STEPS)) sif ();

    control_step_sequencer #(
        .MAX_STEPS  (MAX_STEPS),
        .FETCH_STEPS(FETCH_STEPS),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (sif)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop so that a wedged run still reports
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic obs_t sampleDut();
        obs_t s;
        s.onehot  = sif.step_onehot;
        s.num     = sif.step_num;
        s.stall   = sif.stall;
        s.done    = sif.instr_done;
        s.halted  = sif.halted;
        s.timeout = sif.timeout;
        return s;
    endfunction

    function automatic obs_t modelOutputs();
        obs_t s;
        bit   active;
        active    = (m_mode == M_RUN) || (m_mode == M_WAIT);
        s.onehot  = active ? 8'(1 << m_step) : 8'h00;
        s.num     = 3'(m_step);
        s.stall   = (m_mode == M_WAIT);
        s.done    = m_done;
        s.halted  = (m_mode == M_HALT);
        s.timeout = m_timeout;
        return s;
    endfunction

    task automatic modelReset();
        m_mode    = M_IDLE;
        m_step    = 0;
        m_wait    = 0;
        m_pend    = 0;
        m_timeout = 0;
        m_done    = 0;
    endtask

    // Finishing the current step: a final step ends the instruction, and
    // any other step moves on to the next one.
    task automatic modelFinishStep(input bit last);
        bit is_final;
        is_final = (m_step == MAX_STEPS - 1) || (last && (m_step >= FETCH_STEPS));
        if (is_final) begin
            m_done = 1;
            m_step = 0;
            if (m_pend) begin
                m_mode = M_HALT;
                m_pend = 0;
            end else begin
                m_mode = M_RUN;
            end
        end else begin
            m_step = m_step + 1;
            m_mode = M_RUN;
        end
    endtask

    task automatic modelCycle(input bit run, input bit stop, input bit last,
                              input bit acc, input bit ready);
        m_done = 0;
        if (m_mode == M_IDLE) begin
            if (stop) m_pend = 1;
            if (run) begin
                m_mode = M_RUN;
                m_step = 0;
            end
        end else if (m_mode == M_HALT) begin
            if (run) begin
                if (stop) m_pend = 1;
                m_mode    = M_RUN;
                m_step    = 0;
                m_timeout = 0;
            end
        end else if (m_mode == M_RUN) begin
            if (stop) m_pend = 1;
            if (acc && !ready) begin
                m_mode = M_WAIT;
                m_wait = 1;
            end else begin
                modelFinishStep(last);
            end
        end else begin
            if (stop) m_pend = 1;
            if (ready) begin
                m_wait = 0;
                modelFinishStep(last);
            end else if (m_wait >= WAIT_LIMIT) begin
                m_timeout = 1;
                m_mode    = M_HALT;
                m_step    = 0;
                m_wait    = 0;
                m_pend    = 0;
            end else begin
                m_wait = m_wait + 1;
            end
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then queue the
    // predicted outputs for the next rising edge.
    task automatic applyStimulus(input bit run, input bit stop, input bit last,
                                 input bit acc, input bit ready);
        @(negedge clk);
        sif.run        = run;
        sif.stop       = stop;
        sif.last_step  = last;
        sif.mem_access = acc;
        sif.mem_ready  = ready;
        modelCycle(run, stop, last, acc, ready);
        exp_q.push_back(modelOutputs());
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Asynchronous clear between clock edges. The outputs must drop at once,
    // without waiting for a clock edge.
    task automatic resetPulse(input string name);
        @(negedge clk);
        #2;
        sif.run        = 1'b0;
        sif.stop       = 1'b0;
        sif.last_step  = 1'b0;
        sif.mem_access = 1'b0;
        sif.mem_ready  = 1'b0;
        clear          = 1'b1;
        #1;
        checkOutput(name, 32'(sampleDut()), 32'd0);
        modelReset();
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Scoreboard monitor: one prediction is consumed per rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                obs_t e;
                obs_t a;
                e = exp_q.pop_front();
                a = sampleDut();
                check_count++;
                if (a !== e) begin
                    error_count++;
                    $display("[TB] FAIL scoreboard t=%0t: got onehot=%h num=%0d stall=%b done=%b halted=%b timeout=%b, required onehot=%h num=%0d stall=%b done=%b halted=%b timeout=%b",
                             $time, a.onehot, a.num, a.stall, a.done, a.halted, a.timeout,
                             e.onehot, e.num, e.stall, e.done, e.halted, e.timeout);
                end
            end
        end
    end

    initial begin
        logic [7:0] t1_table [0:6];
        int         stall_seen;
        int         t1_seen;
        int         dead_cycles;
        bit         r_run;
        bit         r_stop;
        bit         r_last;
        bit         r_acc;
        bit         r_ready;

        t1_table[0] = 8'h01; t1_table[1] = 8'h02; t1_table[2] = 8'h04;
        t1_table[3] = 8'h08; t1_table[4] = 8'h10; t1_table[5] = 8'h20;
        t1_table[6] = 8'h01;

        check_count    = 0;
        error_count    = 0;
        clear          = 1'b1;
        sif.run        = 1'b0;
        sif.stop       = 1'b0;
        sif.last_step  = 1'b0;
        sif.mem_access = 1'b0;
        sif.mem_ready  = 1'b0;
        modelReset();

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", 32'(sampleDut()), 32'd0);
        clear = 1'b0;

        // Scenario 1: plain run, instruction ends on last_step at T5
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b0, (m_mode == M_RUN) && (m_step == 5), 1'b0, 1'b1);
            settle();
            checkOutput($sformatf("t1_onehot_%0d", i), 32'(sif.step_onehot), 32'(t1_table[i]));
        end
        checkOutput("t1_instr_done", 32'(sif.instr_done), 32'd1);

        // Scenario 2: memory access at T1 with mem_ready low for three cycles
        resetPulse("t2_clear");
        stall_seen = 0;
        t1_seen    = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i == 0, 1'b0, 1'b0, (m_mode != M_IDLE) && (m_step == 1),
                          !((i >= 2) && (i <= 4)));
            settle();
            if (sif.stall) stall_seen++;
            if (sif.step_onehot == 8'h02) t1_seen++;
        end
        checkOutput("t2_stall_cycles", 32'(stall_seen), 32'd3);
        checkOutput("t2_t1_hold_cycles", 32'(t1_seen), 32'd4);
        checkOutput("t2_onehot_after", 32'(sif.step_onehot), 32'h04);

        // Scenario 3: mem_ready never comes, so the wait times out
        resetPulse("t3_clear");
        stall_seen = 0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(i == 0, 1'b0, 1'b0, (m_mode != M_IDLE) && (m_step == 1), 1'b0);
            settle();
            if (sif.stall) stall_seen++;
        end
        checkOutput("t3_stall_cycles", 32'(stall_seen), 32'd15);
        checkOutput("t3_timeout", 32'(sif.timeout), 32'd1);
        checkOutput("t3_halted", 32'(sif.halted), 32'd1);
        checkOutput("t3_onehot_zero", 32'(sif.step_onehot), 32'd0);
        checkOutput("t3_no_done", 32'(sif.instr_done), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("t3_timeout_cleared", 32'(sif.timeout), 32'd0);
        checkOutput("t3_restart_t0", 32'(sif.step_onehot), 32'h01);

        // Scenario 4: run with stop together gives a single-step of one
        // instruction ending at T4
        resetPulse("t4_clear");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i == 0, i == 0, (m_mode == M_RUN) && (m_step == 4), 1'b0, 1'b1);
            settle();
        end
        checkOutput("t4_halted", 32'(sif.halted), 32'd1);
        checkOutput("t4_instr_done", 32'(sif.instr_done), 32'd1);
        checkOutput("t4_onehot_zero", 32'(sif.step_onehot), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Scenario 5: last_step during fetch is ignored, and T7 forces the end
        resetPulse("t5_clear");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b0, (m_mode == M_RUN) && (m_step == 1), 1'b0, 1'b1);
            settle();
            if (i == 7) checkOutput("t5_reach_t7", 32'(sif.step_onehot), 32'h80);
        end
        checkOutput("t5_wrap_t0", 32'(sif.step_onehot), 32'h01);
        checkOutput("t5_instr_done", 32'(sif.instr_done), 32'd1);

        // Scenario 6: clear while stalled at T2
        resetPulse("t6_clear_pre");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i == 0, 1'b0, 1'b0, (m_mode != M_IDLE) && (m_step == 2), 1'b0);
        end
        settle();
        checkOutput("t6_in_wait", 32'(sif.stall), 32'd1);
        resetPulse("t6_clear_in_wait");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        settle();
        checkOutput("t6_idle_onehot", 32'(sif.step_onehot), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic, including occasional dead-memory bursts that
        // run long enough to time out
        dead_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                resetPulse("rand_clear");
            end
            if ($urandom_range(0, 299) == 0) dead_cycles = 20;
            r_run   = ($urandom_range(0, 3) == 0);
            r_stop  = ($urandom_range(0, 19) == 0);
            r_last  = ($urandom_range(0, 5) == 0);
            r_acc   = ($urandom_range(0, 2) == 0);
            r_ready = (dead_cycles > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (dead_cycles > 0) dead_cycles--;
            applyStimulus(r_run, r_stop, r_last, r_acc, r_ready);
        end

        settle();
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
